// File: rtl/uvmt_udma_rx_tcdm_wr_bridge.sv
// ============================================================================
// Module  : uvmt_udma_rx_tcdm_wr_bridge
// Brief   : Turns Rx-channel L2 write beats into 32-bit TCDM write requests
//           through a beat FIFO, with a bound on in-flight writes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uvmt_udma_rx_tcdm_wr_bridge #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [31:0]                   in_addr_i,
  input  logic [31:0]                   in_data_i,
  input  logic [1:0]                    in_datasize_i,
  output logic                          tcdm_req_o,
  input  logic                          tcdm_gnt_i,
  output logic [31:0]                   tcdm_addr_o,
  output logic                          tcdm_we_o,
  output logic [3:0]                    tcdm_be_o,
  output logic [31:0]                   tcdm_wdata_o,
  input  logic                          tcdm_r_valid_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_o,
  output logic                          idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [29:0]   mem_addr_q  [FIFO_DEPTH];
  logic [3:0]    mem_be_q    [FIFO_DEPTH];
  logic [31:0]   mem_wdata_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    outst_q, outst_d;
  logic          ready_en_q;
  logic          err_q;

  logic          empty, full;
  logic          bad_beat, accept, push, pop, rsp;
  logic [3:0]    in_be;
  logic [31:0]   in_wdata;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));

  // Ready is held low through reset and only depends on stored state.
  assign in_ready_o = ready_en_q && !full;

  always_comb begin
    bad_beat = 1'b0;
    in_be    = 4'b1111;
    case (in_datasize_i)
      2'd0:    in_be = 4'b0001 << in_addr_i[1:0];
      2'd1: begin
        in_be    = 4'b0011 << {in_addr_i[1], 1'b0};
        bad_beat = in_addr_i[0];
      end
      2'd2:    bad_beat = |in_addr_i[1:0];
      default: bad_beat = 1'b1;
    endcase
  end

  assign in_wdata = in_data_i << {in_addr_i[1:0], 3'b000};

  assign accept = in_valid_i && in_ready_o;
  assign push   = accept && !bad_beat;

  // A response in the same cycle frees a slot, so the limit can be bypassed.
  assign tcdm_req_o = !empty &&
                      ((outst_q < 4'(MAX_OUTSTANDING)) || tcdm_r_valid_i);
  assign pop        = tcdm_req_o && tcdm_gnt_i;
  assign rsp        = tcdm_r_valid_i && (outst_q != '0);

  assign tcdm_we_o    = tcdm_req_o;
  assign tcdm_addr_o  = empty ? 32'h0 : {mem_addr_q[rd_ptr_q], 2'b00};
  assign tcdm_be_o    = empty ? 4'h0  : mem_be_q[rd_ptr_q];
  assign tcdm_wdata_o = empty ? 32'h0 : mem_wdata_q[rd_ptr_q];

  assign fifo_level_o = level_q;
  assign err_o        = err_q;
  assign idle_o       = empty && (outst_q == '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({pop, rsp})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Storage is not reset; the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]  <= in_addr_i[31:2];
      mem_be_q[wr_ptr_q]    <= in_be;
      mem_wdata_q[wr_ptr_q] <= in_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      outst_q    <= '0;
      ready_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      err_q      <= accept && bad_beat;
      level_q    <= level_d;
      outst_q    <= outst_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uvmt_udma_rx_tcdm_wr_bridge.sv
// ============================================================================
// Module  : tb_uvmt_udma_rx_tcdm_wr_bridge
// Brief   : Directed self-checking bench for the Rx TCDM write bridge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uvmt_udma_rx_tcdm_wr_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_addr_i = '0;
  logic [31:0] in_data_i = '0;
  logic [1:0]  in_datasize_i = '0;
  logic        tcdm_req_o;
  logic        tcdm_gnt_i = 1'b0;
  logic [31:0] tcdm_addr_o;
  logic        tcdm_we_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_wdata_o;
  logic        tcdm_r_valid_i = 1'b0;
  logic [2:0]  fifo_level_o;
  logic        err_o;
  logic        idle_o;

  int tests = 0;
  int fails = 0;

  uvmt_udma_rx_tcdm_wr_bridge #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_datasize_i(in_datasize_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_addr_o(tcdm_addr_o),
    .tcdm_we_o(tcdm_we_o), .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .fifo_level_o(fifo_level_o),
    .err_o(err_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic g, input logic rv);
    @(negedge clk_i);
    in_valid_i = v; in_addr_i = a; in_data_i = d; in_datasize_i = s;
    tcdm_gnt_i = g; tcdm_r_valid_i = rv;
    #1;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if ({in_ready_o, tcdm_req_o, tcdm_we_o, tcdm_be_o, err_o, idle_o, fifo_level_o} !== {3'b000, 4'h0, 2'b01, 3'd0}) begin
      fails++; $display("FAIL reset_ctrl: ready=%b req=%b we=%b be=%h err=%b idle=%b lvl=%0d expected 0,0,0,0,0,1,0",
        in_ready_o, tcdm_req_o, tcdm_we_o, tcdm_be_o, err_o, idle_o, fifo_level_o);
    end
    tests++;
    if ({tcdm_addr_o, tcdm_wdata_o} !== 64'h0) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h expected 0", tcdm_addr_o, tcdm_wdata_o);
    end
    @(negedge clk_i); rstn_i = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (in_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after: got %b expected 1", in_ready_o);
    end
  endtask

  task automatic test_word;
    step(1, 32'h1C00_0010, 32'hDEAD_BEEF, 2'd2, 1, 0);
    tests++;
    if (in_ready_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
      fails++; $display("FAIL word_accept: ready=%b req=%b expected 1,0", in_ready_o, tcdm_req_o);
    end
    step(0, 0, 0, 0, 1, 0);
    tests++;
    if ({tcdm_req_o, tcdm_we_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o} !== {2'b11, 32'h1C00_0010, 4'hF, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL word_req: req=%b we=%b addr=%h be=%b wdata=%h expected 1,1,1c000010,1111,deadbeef",
        tcdm_req_o, tcdm_we_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o);
    end
    step(0, 0, 0, 0, 0, 1);
    tests++;
    if (tcdm_req_o !== 1'b0 || idle_o !== 1'b0) begin
      fails++; $display("FAIL word_outstanding: req=%b idle=%b expected 0,0", tcdm_req_o, idle_o);
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (idle_o !== 1'b1 || fifo_level_o !== 3'd0) begin
      fails++; $display("FAIL word_idle: idle=%b lvl=%0d expected 1,0", idle_o, fifo_level_o);
    end
  endtask

  task automatic test_lanes;
    step(1, 32'h1C00_0003, 32'h0000_00A5, 2'd0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    tests++;
    if ({tcdm_req_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o} !== {1'b1, 32'h1C00_0000, 4'b1000, 32'hA500_0000}) begin
      fails++; $display("FAIL byte_lane: req=%b addr=%h be=%b wdata=%h expected 1,1c000000,1000,a5000000",
        tcdm_req_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o);
    end
    step(1, 32'h1C00_0002, 32'h0000_1234, 2'd1, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    tests++;
    if ({tcdm_req_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o} !== {1'b1, 32'h1C00_0000, 4'b1100, 32'h1234_0000}) begin
      fails++; $display("FAIL half_lane: req=%b addr=%h be=%b wdata=%h expected 1,1c000000,1100,12340000",
        tcdm_req_o, tcdm_addr_o, tcdm_be_o, tcdm_wdata_o);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (idle_o !== 1'b1) begin
      fails++; $display("FAIL lanes_idle: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_errors;
    logic [1:0] sizes [2];
    logic [31:0] addrs [2];
    sizes[0] = 2'd1; addrs[0] = 32'h1C00_0001;
    sizes[1] = 2'd3; addrs[1] = 32'h1C00_0000;
    for (int i = 0; i < 2; i++) begin
      step(1, addrs[i], 32'h5555_AAAA, sizes[i], 1, 0);
      tests++;
      if (in_ready_o !== 1'b1 || err_o !== 1'b0) begin
        fails++; $display("FAIL err_accept[%0d]: ready=%b err=%b expected 1,0", i, in_ready_o, err_o);
      end
      step(0, 0, 0, 0, 1, 0);
      tests++;
      if ({err_o, tcdm_req_o, fifo_level_o} !== {2'b10, 3'd0}) begin
        fails++; $display("FAIL err_pulse[%0d]: err=%b req=%b lvl=%0d expected 1,0,0", i, err_o, tcdm_req_o, fifo_level_o);
      end
      step(0, 0, 0, 0, 0, 0);
      tests++;
      if (err_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
        fails++; $display("FAIL err_single[%0d]: err=%b req=%b expected 0,0", i, err_o, tcdm_req_o);
      end
    end
  endtask

  task automatic test_full_order;
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h1C00_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 2'd2, 0, 0);
      if (i > 0) begin
        tests++;
        if (tcdm_req_o !== 1'b1 || tcdm_addr_o !== 32'h1C00_0100) begin
          fails++; $display("FAIL full_stable[%0d]: req=%b addr=%h expected 1,1c000100", i, tcdm_req_o, tcdm_addr_o);
        end
      end
    end
    step(1, 32'h1C00_0110, 32'h1000_0004, 2'd2, 0, 0);
    tests++;
    if ({in_ready_o, fifo_level_o, tcdm_req_o, tcdm_addr_o} !== {1'b0, 3'd4, 1'b1, 32'h1C00_0100}) begin
      fails++; $display("FAIL full_state: ready=%b lvl=%0d req=%b addr=%h expected 0,4,1,1c000100",
        in_ready_o, fifo_level_o, tcdm_req_o, tcdm_addr_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 2) step(1, 32'h1C00_0110, 32'h1000_0004, 2'd2, 1, 1);
      else       step(0, 0, 0, 0, 1, 1);
      if (i == 1) begin
        tests++;
        if (in_ready_o !== 1'b1) begin
          fails++; $display("FAIL full_release_ready: got %b expected 1", in_ready_o);
        end
      end
      tests++;
      if (i < 5) begin
        if (tcdm_req_o !== 1'b1 || tcdm_addr_o !== 32'h1C00_0100 + 32'(4 * i) || tcdm_wdata_o !== 32'h1000_0000 + 32'(i)) begin
          fails++; $display("FAIL order[%0d]: req=%b addr=%h wdata=%h expected 1,%h,%h", i, tcdm_req_o,
            tcdm_addr_o, tcdm_wdata_o, 32'h1C00_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        end
      end else if (tcdm_req_o !== 1'b0 || fifo_level_o !== 3'd0) begin
        fails++; $display("FAIL drain_done: req=%b lvl=%0d expected 0,0", tcdm_req_o, fifo_level_o);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (idle_o !== 1'b1) begin
      fails++; $display("FAIL full_idle: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_outstanding;
    int grants = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1, 32'h1C00_0200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'd2, 1, 0);
      else       step(0, 0, 0, 0, 1, 0);
      if (tcdm_req_o === 1'b1) grants++;
    end
    tests++;
    if (grants !== 2 || tcdm_req_o !== 1'b0 || fifo_level_o !== 3'd1) begin
      fails++; $display("FAIL max_outstanding: grants=%0d req=%b lvl=%0d expected 2,0,1", grants, tcdm_req_o, fifo_level_o);
    end
    step(0, 0, 0, 0, 1, 1);
    tests++;
    if (tcdm_req_o !== 1'b1 || tcdm_addr_o !== 32'h1C00_0208) begin
      fails++; $display("FAIL rvalid_bypass: req=%b addr=%h expected 1,1c000208", tcdm_req_o, tcdm_addr_o);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (idle_o !== 1'b1) begin
      fails++; $display("FAIL outstanding_idle: got %b expected 1", idle_o);
    end
  endtask

  task automatic test_reset_midflight;
    for (int i = 0; i < 5; i++)
      step(1, 32'h1C00_0300 + 32'(4 * i), 32'hBEEF_0000 + 32'(i), 2'd2, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (fifo_level_o !== 3'd3 || tcdm_req_o !== 1'b0 || idle_o !== 1'b0) begin
      fails++; $display("FAIL pre_reset: lvl=%0d req=%b idle=%b expected 3,0,0", fifo_level_o, tcdm_req_o, idle_o);
    end
    tcdm_gnt_i = 1'b1; tcdm_r_valid_i = 1'b1;
    rstn_i = 1'b0;
    #1;
    tests++;
    if ({in_ready_o, tcdm_req_o, tcdm_we_o, tcdm_be_o, err_o, idle_o, fifo_level_o, tcdm_addr_o, tcdm_wdata_o}
        !== {3'b000, 4'h0, 2'b01, 3'd0, 64'h0}) begin
      fails++; $display("FAIL async_reset: ready=%b req=%b we=%b be=%h idle=%b lvl=%0d addr=%h wdata=%h expected all 0 except idle=1",
        in_ready_o, tcdm_req_o, tcdm_we_o, tcdm_be_o, idle_o, fifo_level_o, tcdm_addr_o, tcdm_wdata_o);
    end
    step(0, 0, 0, 0, 1, 1);
    @(negedge clk_i); rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1);
      tests++;
      if (tcdm_req_o !== 1'b0 || fifo_level_o !== 3'd0 || idle_o !== 1'b1 || in_ready_o !== 1'b1) begin
        fails++; $display("FAIL post_reset[%0d]: req=%b lvl=%0d idle=%b ready=%b expected 0,0,1,1",
          i, tcdm_req_o, fifo_level_o, idle_o, in_ready_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_full_order();
    test_outstanding();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
